param_counter: RTL

//   Parametrised up/down counter, successor to the fixed 32-bit free-running counter.

---
 rtl/param_counter_pkg.sv | 33 +++
 rtl/param_counter_prescaler.sv | 46 ++++
 rtl/param_counter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/param_counter_pkg.sv
// Shared definitions for param_counter and its prescaler.
// Count direction and bound-mode encodings, the per-edge action priority,
// and a width helper for the prescaler register.
package param_counter_pkg;

    // up_down input encoding
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // SATURATE parameter encoding
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // What the counter does on a given edge, in priority order clear > load > step > hold
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_STEP  = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_CLEAR = 2'd3
    } count_action_e;

    // Prescaler register width; never below one bit so the vector stays legal
    function automatic int unsigned ps_width(input int unsigned prescale);
        int unsigned w;
        if (prescale <= 32'd2) begin
            w = 32'd1;
        end else begin
            w = int'($clog2(prescale));
        end
        return w;
    endfunction

endpackage

// File: rtl/param_counter_prescaler.sv
// counter_prescaler: divides enabled cycles by PRESCALE and emits a step
// request on the last enabled cycle of each group. restart (clear or load in
// the parent) returns the phase to zero. With PRESCALE==1 there is no
// register at all and every enabled cycle is a step.
module counter_prescaler
    import param_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic CLOCK_5,
    input  logic RESET_N,
    input  logic enable,
    input  logic restart,
    output logic step
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic unused_restart;
            assign unused_restart = restart;

            // Every enabled cycle is a step
            assign step = enable;
        end else begin : g_div
            localparam int unsigned      PS_W    = ps_width(PRESCALE);
            localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

            logic [PS_W-1:0] ps_cnt;

            // Step fires on the final enabled cycle of a prescale group
            assign step = enable && (ps_cnt == PS_LAST);

            // Phase counter: frozen while disabled, so a paused run resumes in phase
            always_ff @(posedge CLOCK_5 or negedge RESET_N) begin
                if (!RESET_N) begin
                    ps_cnt <= '0;
                end else if (restart) begin
                    ps_cnt <= '0;
                end else if (enable) begin
                    ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/param_counter.sv
// param_counter: parametrised up/down counter with modulus, wrap or saturate
// at the bounds, enable, prescaler, synchronous clear/load and a registered
// terminal pulse.
// Optional build macro PARAM_COUNTER_CAPTURE_EN adds a capture input and a
// registered capture_out snapshot of the count as it was before the edge.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH:0]   MODULUS  = '0,
    parameter int unsigned      PRESCALE = 1,
    parameter bit               SATURATE = MODE_WRAP
) (
    input  logic             CLOCK_5,
    input  logic             RESET_N,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             terminal
`ifdef PARAM_COUNTER_CAPTURE_EN
    ,
    input  logic             capture,
    output logic [WIDTH-1:0] capture_out
`endif
);

    // MODULUS==0 selects the full binary range
    localparam logic [WIDTH:0]   MOD_M1   = MODULUS - 1'b1;
    localparam logic [WIDTH-1:0] MAX      = (MODULUS == '0) ? '1 : MOD_M1[WIDTH-1:0];
    localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

    logic            step;
    logic            restart;
    logic            at_max;
    logic            at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] cnt_nxt;
    logic            term_nxt;
    count_action_e   action;

    assign restart = clear | load;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLOCK_5 (CLOCK_5),
        .RESET_N (RESET_N),
        .enable  (enable),
        .restart (restart),
        .step    (step)
    );

    // Loaded values beyond the range are pulled back to the top bound
    assign load_clamped = (load_value > MAX) ? MAX : load_value;

    // >= keeps the bound check safe even for an out-of-range count
    assign at_max  = (counter_out >= MAX);
    assign at_zero = (counter_out == '0);

    // Resolve the edge priority: clear over load over step
    always_comb begin
        action = ACT_HOLD;
        if (clear) begin
            action = ACT_CLEAR;
        end else if (load) begin
            action = ACT_LOAD;
        end else if (step) begin
            action = ACT_STEP;
        end
    end

    // Next count and terminal; terminal flags a wrap or arrival at a saturating bound
    always_comb begin
        cnt_nxt  = counter_out;
        term_nxt = 1'b0;
        case (action)
            ACT_CLEAR: cnt_nxt = '0;
            ACT_LOAD:  cnt_nxt = load_clamped;
            ACT_STEP: begin
                if (up_down == DIR_UP) begin
                    if (at_max) begin
                        if (!SAT_MODE) begin
                            cnt_nxt  = '0;
                            term_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt  = counter_out + 1'b1;
                        term_nxt = SAT_MODE && (cnt_nxt == MAX);
                    end
                end else begin
                    if (at_zero) begin
                        if (!SAT_MODE) begin
                            cnt_nxt  = MAX;
                            term_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt  = counter_out - 1'b1;
                        term_nxt = SAT_MODE && (counter_out == WIDTH'(1));
                    end
                end
            end
            default: ;
        endcase
    end

    // Count and terminal registers
    always_ff @(posedge CLOCK_5 or negedge RESET_N) begin
        if (!RESET_N) begin
            counter_out <= '0;
            terminal    <= 1'b0;
        end else begin
            counter_out <= cnt_nxt;
            terminal    <= term_nxt;
        end
    end

`ifdef PARAM_COUNTER_CAPTURE_EN
    // Snapshot of the pre-edge count, regardless of clear/load/enable
    always_ff @(posedge CLOCK_5 or negedge RESET_N) begin
        if (!RESET_N) begin
            capture_out <= '0;
        end else if (capture) begin
            capture_out <= counter_out;
        end
    end
`endif

endmodule
